sync_fifo_hs: RTL and testbench

Parametrised successor to the team's basic synchronous FIFO, built for inter-stage buffering in cache and pipeline paths.
- Valid/ready handshakes on both sides replace raw push/pop, so overflow and underflow are structurally impossible.
- Supports any depth, including non-power-of-two, with explicit pointer wrap.
- Adds an occupancy count, programmable almost-full/almost-empty flags and a synchronous flush.

---
 rtl/sync_fifo_hs.sv | 109 ++++++++++
 tb/tb_sync_fifo_hs.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_hs.sv
// sync_fifo_hs: synchronous FIFO with valid/ready handshakes on both sides,
// any depth (explicit pointer wrap), occupancy count, almost-full/almost-empty
// flags and a synchronous flush.
// Optional build macro SYNC_FIFO_HS_BYPASS_EN: zero-latency bypass while empty.
module sync_fifo_hs #(
    parameter  int DW     = 8,
    parameter  int DEPTH  = 16,
    parameter  int AF_LVL = 14,
    parameter  int AE_LVL = 2,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] count,
    output logic          almost_full,
    output logic          almost_empty
);

    localparam int            PW      = $clog2(DEPTH);
    localparam logic [CW-1:0] C_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF    = CW'(AF_LVL);
    localparam logic [CW-1:0] C_AE    = CW'(AE_LVL);
    localparam logic [PW-1:0] P_LAST  = PW'(DEPTH - 1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_bypass;
    logic w_wr;
    logic w_rd;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == P_LAST) ? '0 : p + PW'(1);
    endfunction

    // Handshake decode; ready/valid come from the count register only
    // (in the bypass build out_valid additionally follows in_valid while empty).
    always_comb begin
        w_full   = (r_count == C_FULL);
        w_empty  = (r_count == '0);
        in_ready = ~w_full;
        w_push   = in_valid & ~w_full & ~clr;
`ifdef SYNC_FIFO_HS_BYPASS_EN
        out_valid = ~w_empty | in_valid;
        out_data  = w_empty ? in_data : r_mem[r_rd_ptr];
        w_bypass  = w_empty & in_valid & out_ready & ~clr;
`else
        out_valid = ~w_empty;
        out_data  = r_mem[r_rd_ptr];
        w_bypass  = 1'b0;
`endif
        // A bypassed word goes straight to the consumer and never touches memory.
        w_wr = w_push & ~w_bypass;
        w_rd = ~w_empty & out_ready & ~clr;
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointer and occupancy registers; clr overrides any coincident handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= f_inc(r_wr_ptr);
            end
            if (w_rd) begin
                r_rd_ptr <= f_inc(r_rd_ptr);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Flags are plain compares on the registered count.
    always_comb begin
        count        = r_count;
        almost_full  = (r_count >= C_AF);
        almost_empty = (r_count <= C_AE);
    end

endmodule

// File: tb/tb_sync_fifo_hs.sv
// tb_sync_fifo_hs: directed bench for sync_fifo_hs (DW=8, DEPTH=5).
// The driver queues each word it knows will be accepted; a negedge monitor
// pops the queue on every consumer handshake and compares the head data.
module tb_sync_fifo_hs;

    localparam int DW    = 8;
    localparam int DEPTH = 5;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] count;
    logic          almost_full;
    logic          almost_empty;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q [$];

    sync_fifo_hs #(
        .DW(DW), .DEPTH(DEPTH), .AF_LVL(4), .AE_LVL(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .almost_full(almost_full), .almost_empty(almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs just after the rising edge; qpush records an
    // accepted word in the scoreboard.
    task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic ordy,
                       input logic c, input bit qpush);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        clr       = c;
        if (qpush) exp_q.push_back(d);
    endtask

    // Consumer-side monitor: inputs are stable between negedge and the next posedge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !clr) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got 0x%0h expected no word", out_data);
            end else begin
                check("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        check("rst_count", 32'(count), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_almost_empty", 32'(almost_empty), 1);
        check("rst_almost_full", 32'(almost_full), 0);
        rst_n = 1'b1;

        // Fill to DEPTH, then offer a sixth word that must be refused.
        cyc(1, 8'h11, 0, 0, 1);
        cyc(1, 8'h22, 0, 0, 1);
        cyc(1, 8'h33, 0, 0, 1);
        cyc(1, 8'h44, 0, 0, 1);
        cyc(1, 8'h55, 0, 0, 1);
        cyc(1, 8'h66, 0, 0, 0);
        check("full_count", 32'(count), 5);
        check("full_in_ready", 32'(in_ready), 0);
        check("full_almost_full", 32'(almost_full), 1);
        check("full_almost_empty", 32'(almost_empty), 0);
        cyc(0, 8'h00, 0, 0, 0);
        check("sixth_refused_count", 32'(count), 5);

        // Drain: first pop on full must reopen in_ready; rd_ptr wraps 4->0.
        cyc(0, 8'h00, 1, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
        check("pop_full_in_ready", 32'(in_ready), 1);
        check("pop_full_count", 32'(count), 4);
        cyc(0, 8'h00, 1, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
        cyc(0, 8'h00, 0, 0, 0);
        check("drain_out_valid", 32'(out_valid), 0);
        check("drain_count", 32'(count), 0);
        check("drain_almost_empty", 32'(almost_empty), 1);

        // Steady state at count 3 with simultaneous push and pop.
        cyc(1, 8'h01, 0, 0, 1);
        cyc(1, 8'h02, 0, 0, 1);
        cyc(1, 8'h03, 0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 8'(8'h04 + i), 1, 0, 1);
        end
        cyc(0, 8'h00, 0, 0, 0);
        check("stream_count", 32'(count), 3);
        check("stream_almost_empty", 32'(almost_empty), 0);

        // Flush at count 4 with a coincident push and pop; both are dropped.
        cyc(1, 8'h18, 0, 0, 1);
        cyc(0, 8'h00, 0, 0, 0);
        check("preclr_count", 32'(count), 4);
        check("preclr_almost_full", 32'(almost_full), 1);
        cyc(1, 8'hEE, 1, 1, 0);
        exp_q.delete();
        cyc(0, 8'h00, 0, 0, 0);
        check("clr_count", 32'(count), 0);
        check("clr_out_valid", 32'(out_valid), 0);
        check("clr_in_ready", 32'(in_ready), 1);

        // One-cycle write-to-read latency into an empty FIFO.
        cyc(1, 8'hA5, 0, 0, 1);
`ifndef SYNC_FIFO_HS_BYPASS_EN
        check("latency_before_edge", 32'(out_valid), 0);
`endif
        cyc(0, 8'h00, 0, 0, 0);
        check("latency_after_valid", 32'(out_valid), 1);
        check("latency_after_data", 32'(out_data), 32'h A5);
        check("latency_count", 32'(count), 1);
        cyc(0, 8'h00, 1, 0, 0);

        // Asynchronous reset mid-stream with count 3.
        cyc(1, 8'hB1, 0, 0, 1);
        cyc(1, 8'hB2, 0, 0, 1);
        cyc(1, 8'hB3, 0, 0, 1);
        cyc(0, 8'h00, 0, 0, 0);
        check("prerst_count", 32'(count), 3);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_count", 32'(count), 0);
        check("async_rst_out_valid", 32'(out_valid), 0);
        check("async_rst_in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;

`ifdef SYNC_FIFO_HS_BYPASS_EN
        // Bypass consumed in the same cycle: nothing stored.
        cyc(1, 8'h3C, 1, 0, 1);
        #1;
        check("bypass_out_valid", 32'(out_valid), 1);
        check("bypass_out_data", 32'(out_data), 32'h3C);
        cyc(0, 8'h00, 0, 0, 0);
        check("bypass_count", 32'(count), 0);
        // Bypass not consumed: word is stored.
        cyc(1, 8'h3C, 0, 0, 1);
        cyc(0, 8'h00, 0, 0, 0);
        check("bypass_stall_count", 32'(count), 1);
        cyc(0, 8'h00, 1, 0, 0);
        cyc(0, 8'h00, 0, 0, 0);
        check("bypass_drain_count", 32'(count), 0);
`endif

        cyc(0, 8'h00, 0, 0, 0);
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
